ibex_rf_msg_loader: RTL and testbench

// - Sequences multi-word message loads into the FF register file.
// - Shares the single RF write port between core writeback and a message stream.
// - Accepts a descriptor (base register, length 1-4 words), then one data word per handshake.
// - Writes words to consecutive registers; core writeback always wins the write port.

---
 rtl/ibex_msg_pkg.sv | 26 ++
 rtl/ibex_rf_wport_mux.sv | 25 ++
 rtl/ibex_rf_msg_loader.sv | 152 +++++++++++++++
 tb/tb_ibex_rf_msg_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_msg_pkg.sv
// Shared types for the RF message loader: FSM states, length type and a wrapped word-address helper.
package ibex_msg_pkg;

  typedef enum logic [1:0] {
    MSG_IDLE = 2'd0,
    MSG_LOAD = 2'd1,
    MSG_DONE = 2'd2
  } msg_state_e;

  typedef logic [1:0] msg_len_t;

  localparam int unsigned MSG_MAX_WORDS = 4;

  // With RV32E only 16 registers exist, so the sum wraps in 4 bits and bit 4 is forced low.
  function automatic logic [4:0] msg_word_addr(input logic [4:0] base,
                                               input msg_len_t   idx,
                                               input logic       rv32e);
    logic [4:0] sum;
    sum = base + {3'b000, idx};
    if (rv32e) begin
      sum[4] = 1'b0;
    end
    return sum;
  endfunction

endpackage

// File: rtl/ibex_rf_wport_mux.sv
// Two-source RF write port mux; the core writeback always wins over the message loader.
module ibex_rf_wport_mux #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 core_we_i,
  input  logic [AddrWidth-1:0] core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  input  logic                 ld_we_i,
  input  logic [AddrWidth-1:0] ld_waddr_i,
  input  logic [DataWidth-1:0] ld_wdata_i,
  output logic                 rf_we_o,
  output logic [AddrWidth-1:0] rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o
);

  logic sel_ld;

  // When neither source writes, address/data still follow the core inputs.
  assign sel_ld     = ld_we_i & ~core_we_i;
  assign rf_we_o    = core_we_i | ld_we_i;
  assign rf_waddr_o = sel_ld ? ld_waddr_i : core_waddr_i;
  assign rf_wdata_o = sel_ld ? ld_wdata_i : core_wdata_i;

endmodule

// File: rtl/ibex_rf_msg_loader.sv
// Loads 1-4 word messages into consecutive RF registers, sharing the write port with core writeback.
// Optional IBEX_RF_MSG_LOADER_PERF_EN adds a saturating stall counter output (stall_cnt_o).
module ibex_rf_msg_loader
  import ibex_msg_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  input  logic [4:0]           desc_addr_i,
  input  msg_len_t             desc_len_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 abort_i,
  input  logic                 core_we_i,
  input  logic [4:0]           core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
`ifdef IBEX_RF_MSG_LOADER_PERF_EN
  output logic [15:0]          stall_cnt_o,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 aborted_o
);

  msg_state_e state_q, state_d;
  logic [4:0] base_q, base_d;
  msg_len_t   len_q, len_d;
  msg_len_t   idx_q, idx_d;
  logic       desc_ready_q, desc_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;

  logic       desc_accept;
  logic       word_accept;
  logic [4:0] word_addr;
  logic       ld_we;

  assign desc_ready_o = desc_ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign aborted_o    = aborted_q;

  assign data_ready_o = (state_q == MSG_LOAD) & ~core_we_i;
  assign desc_accept  = desc_valid_i & desc_ready_q;
  assign word_accept  = data_valid_i & data_ready_o;
  assign word_addr    = msg_word_addr(base_q, idx_q, RV32E);
  // Words aimed at x0 still complete their handshake but never assert the write enable.
  assign ld_we        = word_accept & (word_addr != 5'd0);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    unique case (state_q)
      MSG_IDLE: begin
        if (desc_accept) begin
          base_d  = desc_addr_i;
          len_d   = desc_len_i;
          idx_d   = '0;
          state_d = MSG_LOAD;
        end
      end
      MSG_LOAD: begin
        if (word_accept) begin
          idx_d = idx_q + 2'd1;
        end
        if (abort_i || (word_accept && (idx_q == len_q))) begin
          state_d = MSG_DONE;
        end
      end
      MSG_DONE: state_d = MSG_IDLE;
      default:  state_d = MSG_IDLE;
    endcase
    desc_ready_d = (state_d == MSG_IDLE);
    busy_d       = (state_d != MSG_IDLE);
    done_d       = (state_d == MSG_DONE);
    aborted_d    = (state_d == MSG_DONE) && (state_q == MSG_LOAD) && abort_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= MSG_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      desc_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      desc_ready_q <= desc_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

`ifdef IBEX_RF_MSG_LOADER_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Counts cycles where a pending word lost the write port to the core.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (desc_accept) begin
      stall_cnt_d = '0;
    end else if ((state_q == MSG_LOAD) && data_valid_i && core_we_i &&
                 (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  ibex_rf_wport_mux #(
    .DataWidth (DataWidth),
    .AddrWidth (5)
  ) u_wport_mux (
    .core_we_i    (core_we_i),
    .core_waddr_i (core_waddr_i),
    .core_wdata_i (core_wdata_i),
    .ld_we_i      (ld_we),
    .ld_waddr_i   (word_addr),
    .ld_wdata_i   (data_i),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o)
  );

endmodule

// File: tb/tb_ibex_rf_msg_loader.sv
// Self-checking bench for ibex_rf_msg_loader: directed vector table, hand sequences and a randomized
// message stream checked against a message-level reference model.
module tb_ibex_rf_msg_loader;

  typedef struct {
    logic        descValid;
    logic [4:0]  descAddr;
    logic [1:0]  descLen;
    logic        dataValid;
    logic [31:0] data;
    logic        abort;
    logic        coreWe;
    logic [4:0]  coreAddr;
    logic [31:0] coreData;
  } stim_t;

  typedef struct {
    stim_t       in;
    logic        descReady;
    logic        dataReady;
    logic        rfWe;
    logic [4:0]  rfAddr;
    logic [31:0] rfData;
    logic        busy;
    logic        done;
    logic        aborted;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic        descValid;
  logic        descReady;
  logic [4:0]  descAddr;
  logic [1:0]  descLen;
  logic        dataValid;
  logic        dataReady;
  logic [31:0] dataIn;
  logic        abortIn;
  logic        coreWe;
  logic [4:0]  coreAddr;
  logic [31:0] coreData;
  logic        rfWe;
  logic [4:0]  rfAddr;
  logic [31:0] rfData;
  logic        busy;
  logic        done;
  logic        aborted;
`ifdef IBEX_RF_MSG_LOADER_PERF_EN
  logic [15:0] stallCnt;
`endif

  int errors = 0;
  int checks = 0;

  ibex_rf_msg_loader #(
    .RV32E     (1'b0),
    .DataWidth (32)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .desc_valid_i (descValid),
    .desc_ready_o (descReady),
    .desc_addr_i  (descAddr),
    .desc_len_i   (descLen),
    .data_valid_i (dataValid),
    .data_ready_o (dataReady),
    .data_i       (dataIn),
    .abort_i      (abortIn),
    .core_we_i    (coreWe),
    .core_waddr_i (coreAddr),
    .core_wdata_i (coreData),
    .rf_we_o      (rfWe),
    .rf_waddr_o   (rfAddr),
    .rf_wdata_o   (rfData),
`ifdef IBEX_RF_MSG_LOADER_PERF_EN
    .stall_cnt_o  (stallCnt),
`endif
    .busy_o       (busy),
    .done_o       (done),
    .aborted_o    (aborted)
  );

  // Free-running clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t st(input logic dv, input logic [4:0] da, input logic [1:0] dl,
                               input logic wv, input logic [31:0] wd, input logic ab,
                               input logic cw, input logic [4:0] ca, input logic [31:0] cd);
    stim_t s;
    s.descValid = dv; s.descAddr = da; s.descLen = dl;
    s.dataValid = wv; s.data = wd; s.abort = ab;
    s.coreWe = cw; s.coreAddr = ca; s.coreData = cd;
    return s;
  endfunction

  function automatic vec_t vec(input stim_t s, input logic dr, input logic wr, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd, input logic by,
                               input logic dn, input logic ab);
    vec_t v;
    v.in = s; v.descReady = dr; v.dataReady = wr; v.rfWe = we; v.rfAddr = wa;
    v.rfData = wd; v.busy = by; v.done = dn; v.aborted = ab;
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit later, well before the rising edge.
  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    descValid = s.descValid; descAddr = s.descAddr; descLen = s.descLen;
    dataValid = s.dataValid; dataIn = s.data; abortIn = s.abort;
    coreWe = s.coreWe; coreAddr = s.coreAddr; coreData = s.coreData;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkVector(input string tag, input vec_t v);
    checkOutput({tag, ".descReady"}, 32'(descReady), 32'(v.descReady));
    checkOutput({tag, ".dataReady"}, 32'(dataReady), 32'(v.dataReady));
    checkOutput({tag, ".rfWe"},      32'(rfWe),      32'(v.rfWe));
    checkOutput({tag, ".rfAddr"},    32'(rfAddr),    32'(v.rfAddr));
    checkOutput({tag, ".rfData"},    rfData,         v.rfData);
    checkOutput({tag, ".busy"},      32'(busy),      32'(v.busy));
    checkOutput({tag, ".done"},      32'(done),      32'(v.done));
    checkOutput({tag, ".aborted"},   32'(aborted),   32'(v.aborted));
  endtask

  // Directed table, reset/perf sequences, then randomized messages against the model.
  initial begin
    vec_t  tbl[$];
    stim_t idleS;
    logic [31:0] wA, wB, wC, wD;

    idleS = st(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wA = 32'hA0A0_0001; wB = 32'hB0B0_0002; wC = 32'hC0C0_0003; wD = 32'hD0D0_0004;

    rstN = 1'b0;
    applyStimulus(idleS);
    applyStimulus(st(0, 0, 0, 1, 32'h77, 1, 1, 5'd4, 32'h99));
    checkVector("reset", vec(idleS, 1, 0, 1, 5'd4, 32'h99, 0, 0, 0));
    rstN = 1'b1;

    // desc(5,3), four back-to-back words
    tbl.push_back(vec(st(1, 5'd5, 2'd3, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(st(0, 0, 0, 1, wA, 0, 0, 0, 0), 0, 1, 1, 5'd5, wA, 1, 0, 0));
    tbl.push_back(vec(st(0, 0, 0, 1, wB, 0, 0, 0, 0), 0, 1, 1, 5'd6, wB, 1, 0, 0));
    tbl.push_back(vec(st(0, 0, 0, 1, wC, 0, 0, 0, 0), 0, 1, 1, 5'd7, wC, 1, 0, 0));
    tbl.push_back(vec(st(0, 0, 0, 1, wD, 0, 0, 0, 0), 0, 1, 1, 5'd8, wD, 1, 0, 0));
    tbl.push_back(vec(st(1, 5'd9, 2'd0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 1, 1, 0));
    // desc(10,1) with a core write stealing the first word cycle
    tbl.push_back(vec(st(1, 5'd10, 2'd1, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(st(0, 0, 0, 1, 32'h1111, 0, 1, 5'd3, 32'hCAFE), 0, 0, 1, 5'd3, 32'hCAFE, 1, 0, 0));
    tbl.push_back(vec(st(0, 0, 0, 1, 32'h1111, 0, 0, 0, 0), 0, 1, 1, 5'd10, 32'h1111, 1, 0, 0));
    tbl.push_back(vec(st(0, 0, 0, 1, 32'h2222, 0, 0, 0, 0), 0, 1, 1, 5'd11, 32'h2222, 1, 0, 0));
    tbl.push_back(vec(idleS, 0, 0, 0, 0, 0, 1, 1, 0));
    // desc(30,3): wrap through x0
    tbl.push_back(vec(st(1, 5'd30, 2'd3, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(st(0, 0, 0, 1, 32'd1, 0, 0, 0, 0), 0, 1, 1, 5'd30, 32'd1, 1, 0, 0));
    tbl.push_back(vec(st(0, 0, 0, 1, 32'd2, 0, 0, 0, 0), 0, 1, 1, 5'd31, 32'd2, 1, 0, 0));
    tbl.push_back(vec(st(0, 0, 0, 1, 32'd3, 0, 0, 0, 0), 0, 1, 0, 5'd0, 32'd0, 1, 0, 0));
    tbl.push_back(vec(st(0, 0, 0, 1, 32'd4, 0, 0, 0, 0), 0, 1, 1, 5'd1, 32'd4, 1, 0, 0));
    tbl.push_back(vec(idleS, 0, 0, 0, 0, 0, 1, 1, 0));
    // desc(20,3), abort after two words
    tbl.push_back(vec(st(1, 5'd20, 2'd3, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(st(0, 0, 0, 1, 32'h11, 0, 0, 0, 0), 0, 1, 1, 5'd20, 32'h11, 1, 0, 0));
    tbl.push_back(vec(st(0, 0, 0, 1, 32'h22, 0, 0, 0, 0), 0, 1, 1, 5'd21, 32'h22, 1, 0, 0));
    tbl.push_back(vec(st(0, 0, 0, 0, 0, 1, 0, 0, 0), 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(vec(idleS, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(vec(st(0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h1234), 1, 0, 1, 5'd7, 32'h1234, 0, 0, 0));
    // abort in IDLE is ignored
    tbl.push_back(vec(st(0, 0, 0, 0, 0, 1, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(idleS, 1, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].in);
      checkVector($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset mid-LOAD: back to IDLE without done, then a new descriptor is taken at once
    applyStimulus(st(1, 5'd2, 2'd3, 0, 0, 0, 0, 0, 0));
    applyStimulus(st(0, 0, 0, 1, 32'h33, 0, 0, 0, 0));
    checkVector("midrst.word", vec(idleS, 0, 1, 1, 5'd2, 32'h33, 1, 0, 0));
    rstN = 1'b0;
    applyStimulus(st(1, 5'd15, 2'd0, 0, 0, 0, 0, 0, 0));
    rstN = 1'b1;
    checkVector("midrst.idle", vec(idleS, 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(st(0, 0, 0, 1, 32'h55, 0, 0, 0, 0));
    checkVector("midrst.load", vec(idleS, 0, 1, 1, 5'd15, 32'h55, 1, 0, 0));
    applyStimulus(idleS);
    checkVector("midrst.done", vec(idleS, 0, 0, 0, 0, 0, 1, 1, 0));

`ifdef IBEX_RF_MSG_LOADER_PERF_EN
    applyStimulus(st(1, 5'd12, 2'd0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(st(0, 0, 0, 1, 32'h66, 0, 1, 5'd9, 32'h1));
    end
    applyStimulus(st(0, 0, 0, 0, 0, 1, 0, 0, 0));
    checkOutput("perf.count3", 32'(stallCnt), 32'd3);
    applyStimulus(idleS);
    applyStimulus(st(1, 5'd4, 2'd0, 0, 0, 0, 0, 0, 0));
    applyStimulus(st(0, 0, 0, 1, 32'h5, 0, 0, 0, 0));
    checkOutput("perf.cleared", 32'(stallCnt), 32'd0);
    applyStimulus(idleS);
`endif

    // Randomized messages; the model tracks words remaining and the next target register
    for (int m = 0; m < 150; m++) begin
      logic [4:0]  base;
      logic [1:0]  len;
      logic [31:0] words[$];
      int          taken;
      int          cyc;
      bit          finished;
      bit          expAb;
      int          gap;

      base = 5'($urandom_range(0, 31));
      len  = 2'($urandom_range(0, 3));
      words.delete();
      for (int k = 0; k <= int'(len); k++) words.push_back($urandom);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        logic        cw;
        logic [4:0]  ca;
        logic [31:0] cd;
        cw = ($urandom_range(0, 1) == 0);
        ca = 5'($urandom_range(0, 31));
        cd = $urandom;
        applyStimulus(st(0, 0, 0, 0, 0, 0, cw, ca, cd));
        checkVector($sformatf("rnd%0d.gap", m), vec(idleS, 1, 0, cw, ca, cd, 0, 0, 0));
      end
      applyStimulus(st(1, base, len, 0, 0, 0, 0, 0, 0));
      checkVector($sformatf("rnd%0d.desc", m), vec(idleS, 1, 0, 0, 0, 0, 0, 0, 0));

      taken = 0; cyc = 0; finished = 0; expAb = 0;
      while (!finished && cyc < 64) begin
        logic        cw, dv, ab, accept, lastWord, ldWrite, expWe;
        logic [4:0]  ca, tgt, expAddr;
        logic [31:0] cd, wd, expData;
        cw = ($urandom_range(0, 2) == 0);
        dv = ($urandom_range(0, 2) != 0);
        ca = 5'($urandom_range(0, 31));
        cd = $urandom;
        wd = dv ? words[0] : $urandom;
        accept   = dv && !cw;
        lastWord = accept && (taken == int'(len));
        ab       = !lastWord && ($urandom_range(0, 15) == 0);
        tgt      = 5'((int'(base) + taken) % 32);
        ldWrite  = accept && (tgt != 5'd0);
        expWe    = cw || ldWrite;
        expAddr  = ldWrite ? tgt : ca;
        expData  = ldWrite ? wd : cd;
        applyStimulus(st(0, 0, 0, dv, wd, ab, cw, ca, cd));
        checkVector($sformatf("rnd%0d.c%0d", m, cyc),
                    vec(idleS, 0, !cw, expWe, expAddr, expData, 1, 0, 0));
        if (accept) begin
          void'(words.pop_front());
          taken++;
        end
        if (lastWord || ab) begin
          finished = 1;
          expAb    = ab;
        end
        cyc++;
      end
      if (!finished) begin
        checks++;
        errors++;
        $display("[TB] FAIL rnd%0d.timeout: message not finished after %0d cycles, expected completion", m, cyc);
      end
      applyStimulus(idleS);
      checkVector($sformatf("rnd%0d.done", m), vec(idleS, 0, 0, 0, 0, 0, 1, 1, expAb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so a stuck run still terminates with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
